// File: rtl/uart_pkg.sv
// Shared types and default frame constants for the UART core.
package uart_pkg;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: start clears the count, half/full ticks mark the bit centre and bit end.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign half_tick = run && (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = run && (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= full_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: independent TX and RX state machines sharing only the clock and reset.
// Even parity on both directions is enabled by defining UART_CORE_PARITY_EN.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

`ifdef UART_CORE_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t            tx_state, tx_state_nx;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BW-1:0]        tx_bit_cnt;
    logic                 tx_par, tx_armed, tx_fire, tx_tick, tx_half_unused;

    // A word moves on a rising edge where tx_valid && tx_ready; tx_valid may not wait on tx_ready,
    // and tx_data is sampled only on that edge.
    assign tx_ready = tx_armed && (tx_state == TX_IDLE);
    assign tx_fire  = tx_valid && tx_ready;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (tx_fire),
        .run       (tx_state != TX_IDLE),
        .half_tick (tx_half_unused),
        .full_tick (tx_tick)
    );

    always_comb begin
        tx_state_nx = tx_state;
        tx          = 1'b1;
        case (tx_state)
            TX_IDLE:   if (tx_fire) tx_state_nx = TX_START;
            TX_START: begin
                tx = 1'b0;
                if (tx_tick) tx_state_nx = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_shift[0];
                if (tx_tick && tx_bit_cnt == LAST_DATA) tx_state_nx = PARITY_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx = tx_par;
                if (tx_tick) tx_state_nx = TX_STOP;
            end
            TX_STOP:   if (tx_tick && tx_bit_cnt == LAST_STOP) tx_state_nx = TX_IDLE;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    // tx_armed keeps tx_ready low through reset and lifts it on the first released edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            tx_armed   <= 1'b0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            tx_bit_cnt <= '0;
        end else begin
            tx_state <= tx_state_nx;
            tx_armed <= 1'b1;
            if (tx_fire) begin
                tx_shift   <= tx_data;
                tx_par     <= ^tx_data;
                tx_bit_cnt <= '0;
            end else if (tx_tick) begin
                if (tx_state == TX_DATA) begin
                    tx_shift   <= tx_shift >> 1;
                    tx_bit_cnt <= (tx_bit_cnt == LAST_DATA) ? '0 : tx_bit_cnt + 1'b1;
                end else if (tx_state == TX_STOP) begin
                    tx_bit_cnt <= tx_bit_cnt + 1'b1;
                end
            end
        end
    end

    rx_state_t            rx_state, rx_state_nx;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BW-1:0]        rx_bit_cnt;
    logic                 rx_s1, rx_s2, rx_par_bad, rx_half, rx_tick, rx_run, rx_tmr_start, rx_stop_eval;

    assign rx_run       = rx_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP};
    assign rx_stop_eval = (rx_state == RX_STOP) && rx_tick;
    // Restarting at the start-bit centre makes every later full tick land on a bit centre.
    assign rx_tmr_start = ((rx_state == RX_IDLE) && !rx_s2) ||
                          ((rx_state == RX_START) && rx_half && !rx_s2);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (rx_tmr_start),
        .run       (rx_run),
        .half_tick (rx_half),
        .full_tick (rx_tick)
    );

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_s2) rx_state_nx = RX_START;
            RX_START:     if (rx_half) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_bit_cnt == LAST_DATA) rx_state_nx = PARITY_EN ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_tick) rx_state_nx = RX_STOP;
            RX_STOP:      if (rx_tick) rx_state_nx = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s2) rx_state_nx = RX_IDLE;
            default:      rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state     <= RX_IDLE;
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_shift     <= '0;
            rx_bit_cnt   <= '0;
            rx_par_bad   <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= rx;
            rx_s2        <= rx_s1;
            rx_state     <= rx_state_nx;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_bit_cnt <= '0;
                    rx_par_bad <= 1'b0;
                end
                RX_DATA: if (rx_tick) begin
                    rx_shift   <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bit_cnt <= (rx_bit_cnt == LAST_DATA) ? '0 : rx_bit_cnt + 1'b1;
                end
                RX_PARITY: if (rx_tick) rx_par_bad <= ^{rx_s2, rx_shift};
                RX_STOP: if (rx_tick) begin
                    if (!rx_s2) begin
                        rx_frame_err <= 1'b1;
                    end else if (!(PARITY_EN && rx_par_bad)) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_CORE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) rx_parity_err <= 1'b0;
        else        rx_parity_err <= rx_stop_eval && rx_par_bad;
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core (8 data bits, 16 clocks/bit, 1 stop bit); parity cases
// are added when UART_CORE_PARITY_EN is defined.
module tb_uart_core;
    import uart_pkg::*;

    localparam int DB  = 8;
    localparam int CPB = 16;
`ifdef UART_CORE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx, rx;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_frame_err, rx_parity_err;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, dbl_cnt = 0;
    logic prev_valid = 1'b0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] got_q[$];

    // RX output monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            got_q.push_back(rx_data);
            if (prev_valid) dbl_cnt++;
        end
        if (rx_frame_err) ferr_cnt++;
        if (rx_parity_err) perr_cnt++;
        prev_valid = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DB-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (PAR == 1 && idx == DB + 1) return ^d;
        return 1'b1;
    endfunction

    // Called at posedge+1; returns at the handshake edge +1 (first cycle of the start bit).
    task automatic tx_send(input logic [DB-1:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_ready_wait", tx_ready, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic tx_frame_check(input logic [DB-1:0] d, output logic [15:0] mids);
        int low_cnt;
        int ok;
        low_cnt = 0;
        mids = '0;
        for (int b = 0; b < NB; b++) begin
            ok = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx === exp_bit(d, b)) ok++;
                if (tx_ready === 1'b0) low_cnt++;
                if (c == CPB / 2) mids[b] = tx;
            end
            check($sformatf("tx_bit%0d_cycles", b), ok, CPB);
        end
        check("tx_ready_low_cycles", low_cnt, NB * CPB);
        @(negedge clk);
        check("tx_ready_after_frame", tx_ready, 1);
        check("tx_idle_after_frame", tx, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_bit(input logic v);
        rx_drv = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [DB-1:0] d, input logic stop, input logic bad_par);
        rx_bit(1'b0);
        for (int i = 0; i < DB; i++) rx_bit(d[i]);
        if (PAR == 1) rx_bit(^d ^ bad_par);
        rx_bit(stop);
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [DB-1:0] data;
        logic          stop;
        logic          bad_par;
        logic          exp_valid;
        logic          exp_ferr;
        logic          exp_perr;
        logic [DB-1:0] exp_data;
    } rx_vec_t;

    rx_vec_t       vecs[$];
    logic [15:0]   mids;
    logic [DB-1:0] e, g;
    int            vb, fb, pb, n, low;

    initial begin
        vecs.push_back('{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF});
`ifdef UART_CORE_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
`endif

        // Reset state, then release
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_frame_err", rx_frame_err, 0);
        check("rst_rx_parity_err", rx_parity_err, 0);
        check("rst_rx_data", rx_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rel_tx_ready_before_edge", tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("rel_tx_ready_first_edge", tx_ready, 1);
        @(posedge clk);
        #1;

        // TX 0xA5: bit timing and the bit pattern sampled at each centre
        tx_send(8'hA5);
        tx_frame_check(8'hA5, mids);
        check("tx_a5_pattern", mids, (PAR == 1) ? 16'h054A : 16'h034A);

`ifdef UART_CORE_PARITY_EN
        tx_send(8'h07);
        tx_frame_check(8'h07, mids);
        check("tx_parity_bit_07", mids[DB+1], 1);
`endif

        // Loopback of two back-to-back words
        loop_en = 1'b1;
        vb = valid_cnt; fb = ferr_cnt; pb = perr_cnt;
        got_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        tx_send(8'h3C);
        tx_send(8'hFF);
        n = 0;
        while (valid_cnt < vb + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("loop_valid_count", valid_cnt - vb, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            check("loop_data", g, e);
        end
        repeat (40) @(posedge clk);
        #1;
        check("loop_frame_err", ferr_cnt - fb, 0);
        check("loop_parity_err", perr_cnt - pb, 0);
        loop_en = 1'b0;

        // 4-cycle low glitch is a false start
        vb = valid_cnt; fb = ferr_cnt;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_valid", valid_cnt - vb, 0);
        check("glitch_frame_err", ferr_cnt - fb, 0);
        check("glitch_rx_idle", 32'(dut.rx_state), 32'(RX_IDLE));

        // Table of received frames
        for (int i = 0; i < vecs.size(); i++) begin
            vb = valid_cnt; fb = ferr_cnt; pb = perr_cnt;
            got_q.delete();
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            rx_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par);
            check($sformatf("rx_vec%0d_valid", i), valid_cnt - vb, 32'(vecs[i].exp_valid));
            check($sformatf("rx_vec%0d_frame_err", i), ferr_cnt - fb, 32'(vecs[i].exp_ferr));
            check($sformatf("rx_vec%0d_parity_err", i), perr_cnt - pb, 32'(vecs[i].exp_perr));
            check($sformatf("rx_vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
                check($sformatf("rx_vec%0d_sb", i), g, e);
            end
        end

        // One-cycle reset at cycle 50 of a looped-back TX frame
        loop_en = 1'b1;
        vb = valid_cnt; fb = ferr_cnt;
        tx_send(8'hA5);
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_tx_ready", tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx_ready_after", tx_ready, 1);
        low = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
        end
        check("midrst_tx_aborted", low, 0);
        check("midrst_rx_valid", valid_cnt - vb, 0);
        check("midrst_frame_err", ferr_cnt - fb, 0);
        check("midrst_rx_data", rx_data, 0);
        loop_en = 1'b0;

        check("rx_valid_consecutive", dbl_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
